// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//
// Boot-time program loader that sits between the host byte link and the
// miniRV core. It receives a framed byte stream <len><word0..wordN-1>
// (little-endian, 4 bytes per field), writes each word into core memory
// while the core is held in reset, then releases the core, counts run
// cycles and stops counting when the core signals ebreak.
//
// Parameters
//   BASE_ADDR   byte address of word0; word i lands at BASE_ADDR + 4*i
//   MAX_WORDS   largest accepted len; len==0 or len>MAX_WORDS is an error
//   CLR_CYCLES  cycles mem_reset/reg_reset are held while clearing (>=1)
//
// Ports
//   clk        in   1   clock
//   reset_n    in   1   asynchronous active-low reset
//   in_valid   in   1   stream byte available
//   in_data    in   8   stream byte
//   in_ready   out  1   loader accepts a byte this cycle
//   restart    in   1   one-cycle pulse, honoured only when halted or in error
//   ebreak     in   1   core ebreak indication, sampled only while running
//   rom_wen    out  1   write strobe to core memory
//   rom_addr   out  32  write byte address
//   rom_wdata  out  32  write data
//   mem_reset  out  1   core memory reset
//   reg_reset  out  1   core register-file reset
//   busy       out  1   clearing, receiving or writing
//   halted     out  1   core stopped on ebreak
//   err        out  1   bad length received
//   cycles     out  32  run-cycle count (saturating)
// -----------------------------------------------------------------------------
module prog_loader #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          MAX_WORDS  = 1024,
    parameter int          CLR_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    input  logic        restart,
    input  logic        ebreak,
    output logic        rom_wen,
    output logic [31:0] rom_addr,
    output logic [31:0] rom_wdata,
    output logic        mem_reset,
    output logic        reg_reset,
    output logic        busy,
    output logic        halted,
    output logic        err,
    output logic [31:0] cycles
);

    localparam int IDXW = $clog2(MAX_WORDS + 1);
    localparam int CLRW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_CLEAR,
        S_LEN,
        S_DATA,
        S_WRITE,
        S_RUN,
        S_HALT,
        S_ERR
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [CLRW-1:0] r_clrCnt;
    logic [1:0]      r_byteCnt;
    logic [23:0]     r_asm;
    logic [IDXW-1:0] r_len;
    logic [IDXW-1:0] r_idx;
    logic [31:0]     r_cycles;

    logic            r_inReady;
    logic            r_romWen;
    logic [31:0]     r_romAddr;
    logic [31:0]     r_romWdata;
    logic            r_memReset;
    logic            r_regReset;
    logic            r_busy;
    logic            r_halted;
    logic            r_err;

    logic            w_accept;
    logic            w_lastByte;
    logic [31:0]     w_fullWord;
    logic [IDXW-1:0] w_idxInc;
    logic            w_enterClear;

    // The registered in_ready reflects the current state, so a byte is
    // consumed exactly when the host sees ready and drives valid.
    assign w_accept     = in_valid && r_inReady;
    assign w_lastByte   = w_accept && (r_byteCnt == 2'd3);
    assign w_fullWord   = {in_data, r_asm};
    assign w_idxInc     = r_idx + 1'b1;
    assign w_enterClear = (w_next == S_CLEAR) && (r_state != S_CLEAR);

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_CLEAR: begin
                if (r_clrCnt == CLRW'(CLR_CYCLES - 1)) begin
                    w_next = S_LEN;
                end
            end
            S_LEN: begin
                if (w_lastByte) begin
                    if ((w_fullWord == 32'd0) || (w_fullWord > 32'(MAX_WORDS))) begin
                        w_next = S_ERR;
                    end else begin
                        w_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_lastByte) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (w_idxInc == r_len) begin
                    w_next = S_RUN;
                end else begin
                    w_next = S_DATA;
                end
            end
            S_RUN: begin
                if (ebreak) begin
                    w_next = S_HALT;
                end
            end
            S_HALT, S_ERR: begin
                if (restart) begin
                    w_next = S_CLEAR;
                end
            end
            default: w_next = S_CLEAR;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_next;
        end
    end

    // Clear-phase timer, byte assembly, length and word index. Any entry
    // into S_CLEAR restarts framing from scratch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_clrCnt  <= '0;
            r_byteCnt <= 2'd0;
            r_asm     <= 24'd0;
            r_len     <= '0;
            r_idx     <= '0;
        end else if (w_enterClear) begin
            r_clrCnt  <= '0;
            r_byteCnt <= 2'd0;
            r_asm     <= 24'd0;
            r_idx     <= '0;
        end else begin
            if (r_state == S_CLEAR) begin
                r_clrCnt <= r_clrCnt + 1'b1;
            end else begin
                r_clrCnt <= '0;
            end

            if (w_accept) begin
                r_byteCnt <= r_byteCnt + 2'd1;
                case (r_byteCnt)
                    2'd0:    r_asm[7:0]   <= in_data;
                    2'd1:    r_asm[15:8]  <= in_data;
                    2'd2:    r_asm[23:16] <= in_data;
                    default: r_asm        <= r_asm;
                endcase
            end

            if ((r_state == S_LEN) && w_lastByte) begin
                r_len <= w_fullWord[IDXW-1:0];
            end

            if (r_state == S_WRITE) begin
                r_idx <= w_idxInc;
            end
        end
    end

    // Run-cycle counter: counts every cycle spent in S_RUN, saturating, and is
    // cleared whenever the loader goes back to clearing the core.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cycles <= 32'd0;
        end else if (w_enterClear) begin
            r_cycles <= 32'd0;
        end else if ((r_state == S_RUN) && (r_cycles != 32'hFFFF_FFFF)) begin
            r_cycles <= r_cycles + 32'd1;
        end
    end

    // Outputs are registered from the next state so each flag lines up with
    // the state it describes. The write strobe is raised on the way into
    // S_WRITE, carrying the word just completed; address and data otherwise
    // keep their last values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_inReady  <= 1'b0;
            r_romWen   <= 1'b0;
            r_romAddr  <= 32'd0;
            r_romWdata <= 32'd0;
            r_memReset <= 1'b1;
            r_regReset <= 1'b1;
            r_busy     <= 1'b1;
            r_halted   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_inReady  <= (w_next == S_LEN) || (w_next == S_DATA);
            r_memReset <= (w_next == S_CLEAR);
            r_regReset <= !((w_next == S_RUN) || (w_next == S_HALT));
            r_busy     <= (w_next == S_CLEAR) || (w_next == S_LEN) ||
                          (w_next == S_DATA)  || (w_next == S_WRITE);
            r_halted   <= (w_next == S_HALT);
            r_err      <= (w_next == S_ERR);
            if ((r_state == S_DATA) && (w_next == S_WRITE)) begin
                r_romWen   <= 1'b1;
                r_romAddr  <= BASE_ADDR + {30'(r_idx), 2'b00};
                r_romWdata <= w_fullWord;
            end else begin
                r_romWen   <= 1'b0;
            end
        end
    end

    assign in_ready  = r_inReady;
    assign rom_wen   = r_romWen;
    assign rom_addr  = r_romAddr;
    assign rom_wdata = r_romWdata;
    assign mem_reset = r_memReset;
    assign reg_reset = r_regReset;
    assign busy      = r_busy;
    assign halted    = r_halted;
    assign err       = r_err;
    assign cycles    = r_cycles;

endmodule

// File: tb/tb_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_loader
//
// Self-checking bench for prog_loader. A table of load scenarios is applied in
// a loop; expected memory writes are queued as each word is sent and matched
// against the rom_wen strobes by a monitor. Hand-written sequences cover the
// run/halt/restart flow, ignored control pulses during a load, and an
// asynchronous reset in the middle of a transfer.
// -----------------------------------------------------------------------------
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        restart;
    logic        ebreak;
    logic        rom_wen;
    logic [31:0] rom_addr;
    logic [31:0] rom_wdata;
    logic        mem_reset;
    logic        reg_reset;
    logic        busy;
    logic        halted;
    logic        err;
    logic [31:0] cycles;

    int total = 0;
    int bad   = 0;
    int writeCount = 0;
    logic prevWen = 1'b0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [31:0] lenField;
        int          nWords;
        logic [31:0] seed;
        int          gap;
        bit          expErr;
    } vec_t;

    wr_t  sbQ[$];
    vec_t vecs[6];

    prog_loader dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .restart   (restart),
        .ebreak    (ebreak),
        .rom_wen   (rom_wen),
        .rom_addr  (rom_addr),
        .rom_wdata (rom_wdata),
        .mem_reset (mem_reset),
        .reg_reset (reg_reset),
        .busy      (busy),
        .halted    (halted),
        .err       (err),
        .cycles    (cycles)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every write strobe must match the oldest expected
    // write and last exactly one cycle.
    always @(negedge clk) begin
        if (rom_wen === 1'b1) begin
            writeCount++;
            checkBit("wen_one_cycle", prevWen, 1'b0);
            if (sbQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_write actual addr=%h data=%h required=no write",
                         rom_addr, rom_wdata);
            end else begin
                wr_t exp;
                exp = sbQ.pop_front();
                checkOutput("write_addr", rom_addr, exp.addr);
                checkOutput("write_data", rom_wdata, exp.data);
            end
        end
        prevWen = rom_wen;
    end

    task automatic checkResetValues(input string tag);
        checkBit({tag, "_rom_wen"}, rom_wen, 1'b0);
        checkOutput({tag, "_rom_addr"}, rom_addr, 32'd0);
        checkOutput({tag, "_rom_wdata"}, rom_wdata, 32'd0);
        checkBit({tag, "_mem_reset"}, mem_reset, 1'b1);
        checkBit({tag, "_reg_reset"}, reg_reset, 1'b1);
        checkBit({tag, "_in_ready"}, in_ready, 1'b0);
        checkOutput({tag, "_cycles"}, cycles, 32'd0);
        checkBit({tag, "_busy"}, busy, 1'b1);
        checkBit({tag, "_halted"}, halted, 1'b0);
        checkBit({tag, "_err"}, err, 1'b0);
    endtask

    // Sends one byte; called and returns at a negative edge. The byte is
    // taken on the first rising edge where ready is high.
    task automatic applyStimulus(input logic [7:0] b, input int gap);
        int n;
        for (int i = 0; i < gap; i++) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            total++;
            bad++;
            $display("[TB] FAIL byte_accept_timeout actual in_ready=%b required=1", in_ready);
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic sendWord(input logic [31:0] w, input int gap);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(w[8*k +: 8], gap);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        reset_n  = 1'b0;
        in_valid = 1'b0;
        restart  = 1'b0;
        ebreak   = 1'b0;
        @(negedge clk);
        reset_n  = 1'b1;
    endtask

    task automatic waitRun(input string tag);
        int n;
        n = 0;
        while (reg_reset !== 1'b0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checkBit({tag, "_run_reached"}, reg_reset, 1'b0);
    endtask

    task automatic pulseRestart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    // Sends a whole program; words are queued on the scoreboard as sent.
    task automatic sendProgram(input logic [31:0] words[$], input int gap);
        wr_t e;
        sendWord(32'(words.size()), gap);
        for (int i = 0; i < words.size(); i++) begin
            e.addr = 32'(i) * 32'd4;
            e.data = words[i];
            sbQ.push_back(e);
            sendWord(words[i], gap);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] prog[$];
        logic [31:0] savedCycles;
        int          wcBefore;

        vecs[0] = '{lenField: 32'd1,    nWords: 1, seed: 32'h0010_0513, gap: 0, expErr: 1'b0};
        vecs[1] = '{lenField: 32'd3,    nWords: 3, seed: 32'hA5A5_0001, gap: 1, expErr: 1'b0};
        vecs[2] = '{lenField: 32'd0,    nWords: 0, seed: 32'h0,         gap: 0, expErr: 1'b1};
        vecs[3] = '{lenField: 32'd1025, nWords: 0, seed: 32'h0,         gap: 1, expErr: 1'b1};
        vecs[4] = '{lenField: 32'd4,    nWords: 4, seed: 32'hDEAD_BEEF, gap: 0, expErr: 1'b0};
        vecs[5] = '{lenField: 32'd2,    nWords: 2, seed: 32'h1234_5678, gap: 2, expErr: 1'b0};

        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        restart  = 1'b0;
        ebreak   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkResetValues("por");
        reset_n = 1'b1;
        @(negedge clk);
        checkBit("clear_mem_reset_held", mem_reset, 1'b1);
        checkBit("clear_in_ready_low", in_ready, 1'b0);
        @(negedge clk);
        checkBit("len_mem_reset_released", mem_reset, 1'b0);
        checkBit("len_in_ready", in_ready, 1'b1);

        // Table-driven load scenarios.
        for (int v = 0; v < 6; v++) begin
            doReset();
            wcBefore = writeCount;
            if (vecs[v].expErr) begin
                sendWord(vecs[v].lenField, vecs[v].gap);
                checkBit("badlen_err", err, 1'b1);
                checkBit("badlen_in_ready", in_ready, 1'b0);
                checkBit("badlen_busy", busy, 1'b0);
                in_valid = 1'b1;
                in_data  = 8'h5A;
                repeat (5) @(negedge clk);
                in_valid = 1'b0;
                checkBit("badlen_not_drained", in_ready, 1'b0);
                checkOutput("badlen_no_write", 32'(writeCount - wcBefore), 32'd0);
                pulseRestart();
                checkBit("badlen_restart_busy", busy, 1'b1);
                checkBit("badlen_restart_err", err, 1'b0);
                checkBit("badlen_restart_mem_reset", mem_reset, 1'b1);
            end else begin
                prog.delete();
                for (int i = 0; i < vecs[v].nWords; i++) begin
                    prog.push_back(vecs[v].seed + 32'(i) * 32'h0102_0304);
                end
                sendProgram(prog, vecs[v].gap);
                waitRun("load");
                checkOutput("load_sb_empty", 32'(sbQ.size()), 32'd0);
                checkOutput("load_write_count", 32'(writeCount - wcBefore), 32'(vecs[v].nWords));
                checkBit("load_busy_done", busy, 1'b0);
                checkBit("load_in_ready_run", in_ready, 1'b0);
                sbQ.delete();
            end
        end

        // Run, ebreak, halt and restart.
        doReset();
        prog.delete();
        prog.push_back(32'h0050_0093);
        prog.push_back(32'h0010_0073);
        sendProgram(prog, 0);
        waitRun("halt");
        checkOutput("run_cycles_start", cycles, 32'd0);
        repeat (5) @(negedge clk);
        checkOutput("run_cycles_count", cycles, 32'd5);
        ebreak = 1'b1;
        @(negedge clk);
        ebreak = 1'b0;
        checkBit("halt_halted", halted, 1'b1);
        checkOutput("halt_cycles", cycles, 32'd6);
        savedCycles = cycles;
        repeat (5) @(negedge clk);
        checkOutput("halt_cycles_frozen", cycles, savedCycles);
        checkBit("halt_reg_reset", reg_reset, 1'b0);
        checkBit("halt_busy", busy, 1'b0);
        pulseRestart();
        checkBit("restart_busy", busy, 1'b1);
        checkBit("restart_halted", halted, 1'b0);
        checkBit("restart_reg_reset", reg_reset, 1'b1);
        checkOutput("restart_cycles_cleared", cycles, 32'd0);

        // restart and ebreak pulses while loading are ignored.
        doReset();
        wcBefore = writeCount;
        sendWord(32'd2, 0);
        restart = 1'b1;
        ebreak  = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        ebreak  = 1'b0;
        @(negedge clk);
        checkBit("ignore_busy", busy, 1'b1);
        checkBit("ignore_halted", halted, 1'b0);
        checkBit("ignore_in_ready", in_ready, 1'b1);
        prog.delete();
        prog.push_back(32'hCAFE_0001);
        prog.push_back(32'hCAFE_0002);
        for (int i = 0; i < 2; i++) begin
            wr_t e;
            e.addr = 32'(i) * 32'd4;
            e.data = prog[i];
            sbQ.push_back(e);
            sendWord(prog[i], 1);
        end
        waitRun("ignore");
        checkOutput("ignore_sb_empty", 32'(sbQ.size()), 32'd0);
        checkBit("ignore_halted_run", halted, 1'b0);

        // Asynchronous reset after six bytes of a two-word load.
        sbQ.delete();
        pulseRestart();
        ebreak = 1'b1;
        @(negedge clk);
        ebreak = 1'b0;
        doReset();
        sendWord(32'd2, 0);
        applyStimulus(8'h11, 0);
        applyStimulus(8'h22, 0);
        #2;
        reset_n = 1'b0;
        #1;
        checkResetValues("midreset");
        @(negedge clk);
        reset_n = 1'b1;
        wcBefore = writeCount;
        prog.delete();
        prog.push_back(32'h89AB_CDEF);
        prog.push_back(32'h0123_4567);
        sendProgram(prog, 0);
        waitRun("fresh");
        checkOutput("fresh_sb_empty", 32'(sbQ.size()), 32'd0);
        checkOutput("fresh_write_count", 32'(writeCount - wcBefore), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
